// File: rtl/clock_pkg.sv
// clock_pkg
// Shared definitions for the calendar/time front-panel controller.
//   - state_t      : field-select FSM encoding (RUN, SET_SEC..SET_YEAR), 3 bits
//   - DEF_*        : default cycle constants for a 50 MHz clock
//   - FIELD_*      : bit positions of the one-hot field select; top_counter
//                    uses the same ordering
//   - BTN_*        : index of each button in the debouncer array
//   - field_select : state -> one-hot field select
//   - next_field   : state reached by one mode press
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_SEC   = 3'd1,
    ST_SET_MIN   = 3'd2,
    ST_SET_HOUR  = 3'd3,
    ST_SET_DAY   = 3'd4,
    ST_SET_MONTH = 3'd5,
    ST_SET_YEAR  = 3'd6
  } state_t;

  localparam int unsigned DEF_DB_CYCLES         = 1_000_000;
  localparam int unsigned DEF_RPT_DELAY_CYCLES  = 25_000_000;
  localparam int unsigned DEF_RPT_PERIOD_CYCLES = 5_000_000;
  localparam int unsigned DEF_IDLE_CYCLES       = 1_500_000_000;
  localparam int          IDLE_W                = 31;

  localparam int NUM_FIELDS  = 6;
  localparam int FIELD_SEC   = 0;
  localparam int FIELD_MIN   = 1;
  localparam int FIELD_HOUR  = 2;
  localparam int FIELD_DAY   = 3;
  localparam int FIELD_MONTH = 4;
  localparam int FIELD_YEAR  = 5;

  localparam int NUM_BTNS = 3;
  localparam int BTN_MODE = 0;
  localparam int BTN_INC  = 1;
  localparam int BTN_DEC  = 2;

  function automatic logic [NUM_FIELDS-1:0] field_select(input state_t s);
    logic [NUM_FIELDS-1:0] f;
    f = '0;
    case (s)
      ST_SET_SEC:   f[FIELD_SEC]   = 1'b1;
      ST_SET_MIN:   f[FIELD_MIN]   = 1'b1;
      ST_SET_HOUR:  f[FIELD_HOUR]  = 1'b1;
      ST_SET_DAY:   f[FIELD_DAY]   = 1'b1;
      ST_SET_MONTH: f[FIELD_MONTH] = 1'b1;
      ST_SET_YEAR:  f[FIELD_YEAR]  = 1'b1;
      default:      f = '0;
    endcase
    return f;
  endfunction

  function automatic state_t next_field(input state_t s);
    state_t n;
    case (s)
      ST_RUN:       n = ST_SET_SEC;
      ST_SET_SEC:   n = ST_SET_MIN;
      ST_SET_MIN:   n = ST_SET_HOUR;
      ST_SET_HOUR:  n = ST_SET_DAY;
      ST_SET_DAY:   n = ST_SET_MONTH;
      ST_SET_MONTH: n = ST_SET_YEAR;
      default:      n = ST_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Two-flop synchroniser, counter debouncer and press-edge detector for one
// active-low push-button.
// Ports:
//   clk_50MHz : system clock
//   rst_n     : synchronous active-low reset
//   btn_n     : raw button, active-low, asynchronous to clk_50MHz
//   level     : debounced level, 1 = pressed
//   press     : one-cycle pulse in the cycle the debounced level becomes pressed
module btn_debounce
  import clock_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // Synchroniser works in "pressed" polarity so everything downstream is active-high.
  logic             sync1_reg, sync2_reg;
  logic [1:0]       vld_reg;
  logic             armed_reg, armed_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next   = '0;
    level_next = level_reg;
    press_next = 1'b0;
    armed_next = armed_reg;
    if (sync2_reg != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_next = sync2_reg;
        press_next = sync2_reg & armed_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
    // The synchroniser flops hold reset values for two cycles; only once a
    // genuine sample shows the button released may a later press be reported.
    // A button held through reset therefore has to be released first.
    if (vld_reg[1] && !sync2_reg) begin
      armed_next = 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      vld_reg   <= '0;
      armed_reg <= 1'b0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= ~btn_n;
      sync2_reg <= sync1_reg;
      vld_reg   <= {vld_reg[0], 1'b1};
      armed_reg <= armed_next;
      level_reg <= level_next;
      press_reg <= press_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign level = level_reg;
  assign press = press_reg;

endmodule

// File: rtl/set_mode_ctrl.sv
// set_mode_ctrl
// Front-panel edit controller for top_counter: debounces the mode/inc/dec
// buttons, walks the field-select FSM RUN -> SET_SEC .. SET_YEAR -> RUN,
// issues one-cycle inc/dec pulses and returns to RUN after an idle timeout.
// Build option: define AUTO_REPEAT_EN for hold-to-repeat inc/dec pulses;
// without it each press yields exactly one pulse and no repeat logic exists.
// Ports:
//   clk_50MHz, rst_n                  : clock, synchronous active-low reset
//   btn_mode_n, btn_inc_n, btn_dec_n  : raw active-low buttons (asynchronous)
//   set_sec .. set_year               : one-hot field select (all low in RUN)
//   inc, dec                          : one-cycle edit pulses
//   editing                           : high in every state except RUN
module set_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DB_CYCLES         = DEF_DB_CYCLES,
  parameter int unsigned RPT_DELAY_CYCLES  = DEF_RPT_DELAY_CYCLES,
  parameter int unsigned RPT_PERIOD_CYCLES = DEF_RPT_PERIOD_CYCLES,
  parameter int unsigned IDLE_CYCLES       = DEF_IDLE_CYCLES
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic btn_mode_n,
  input  logic btn_inc_n,
  input  logic btn_dec_n,
  output logic set_sec,
  output logic set_min,
  output logic set_hour,
  output logic set_day,
  output logic set_month,
  output logic set_year,
  output logic inc,
  output logic dec,
  output logic editing
);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES);

  // ---------------------------------------------------------------- buttons
  logic [NUM_BTNS-1:0] btn_raw_n;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;

  assign btn_raw_n[BTN_MODE] = btn_mode_n;
  assign btn_raw_n[BTN_INC]  = btn_inc_n;
  assign btn_raw_n[BTN_DEC]  = btn_dec_n;

  generate
    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_btn_debounce (
        .clk_50MHz(clk_50MHz),
        .rst_n    (rst_n),
        .btn_n    (btn_raw_n[gi]),
        .level    (btn_level[gi]),
        .press    (btn_press[gi])
      );
    end
  endgenerate

  logic mode_ev, inc_ev, dec_ev, inc_lvl, dec_lvl;
  assign mode_ev = btn_press[BTN_MODE];
  assign inc_ev  = btn_press[BTN_INC];
  assign dec_ev  = btn_press[BTN_DEC];
  assign inc_lvl = btn_level[BTN_INC];
  assign dec_lvl = btn_level[BTN_DEC];

  // ---------------------------------------------------------------- state
  state_t                 state_reg, state_next;
  logic [IDLE_W-1:0]      idle_reg, idle_next;
  logic [NUM_FIELDS-1:0]  set_reg;
  logic                   editing_reg;
  logic                   inc_reg, inc_next;
  logic                   dec_reg, dec_next;

  // A fresh press only edits when the other edit button is not held, and a
  // simultaneous mode press takes priority over it.
  logic in_set, inc_fire, dec_fire;
  assign in_set   = (state_reg != ST_RUN);
  assign inc_fire = in_set && !mode_ev && inc_ev && !dec_lvl;
  assign dec_fire = in_set && !mode_ev && dec_ev && !inc_lvl;

  logic rpt_fire;
  logic rpt_is_dec;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX =
    (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ? RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
  localparam int RPT_W = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(RPT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(RPT_PERIOD_CYCLES - 1);

  logic             rpt_active_reg, rpt_active_next;
  logic             rpt_dir_reg, rpt_dir_next;     // 1 = repeating dec
  logic             rpt_first_reg, rpt_first_next; // still waiting out the initial delay
  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic             rpt_held, rpt_other;

  always_comb begin
    rpt_active_next = rpt_active_reg;
    rpt_dir_next    = rpt_dir_reg;
    rpt_first_next  = rpt_first_reg;
    rpt_cnt_next    = rpt_cnt_reg;
    rpt_fire        = 1'b0;
    rpt_held        = rpt_dir_reg ? dec_lvl : inc_lvl;
    rpt_other       = rpt_dir_reg ? inc_lvl : dec_lvl;
    if (inc_fire || dec_fire) begin
      // The initial pulse arms the repeat timer.
      rpt_active_next = 1'b1;
      rpt_dir_next    = dec_fire;
      rpt_first_next  = 1'b1;
      rpt_cnt_next    = '0;
    end else if (rpt_active_reg) begin
      // Release, the second edit button, or any state change ends the repeat;
      // only a brand-new press can start it again.
      if (!rpt_held || rpt_other || mode_ev || !in_set) begin
        rpt_active_next = 1'b0;
        rpt_cnt_next    = '0;
      end else if (rpt_first_reg && rpt_cnt_reg == RPT_DELAY_LAST) begin
        rpt_fire       = 1'b1;
        rpt_first_next = 1'b0;
        rpt_cnt_next   = '0;
      end else if (!rpt_first_reg && rpt_cnt_reg == RPT_PERIOD_LAST) begin
        rpt_fire     = 1'b1;
        rpt_cnt_next = '0;
      end else begin
        rpt_cnt_next = rpt_cnt_reg + 1'b1;
      end
    end
  end

  assign rpt_is_dec = rpt_dir_reg;

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      rpt_active_reg <= 1'b0;
      rpt_dir_reg    <= 1'b0;
      rpt_first_reg  <= 1'b0;
      rpt_cnt_reg    <= '0;
    end else begin
      rpt_active_reg <= rpt_active_next;
      rpt_dir_reg    <= rpt_dir_next;
      rpt_first_reg  <= rpt_first_next;
      rpt_cnt_reg    <= rpt_cnt_next;
    end
  end
`else
  assign rpt_fire   = 1'b0;
  assign rpt_is_dec = 1'b0;
`endif

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    idle_next  = idle_reg;
    inc_next   = 1'b0;
    dec_next   = 1'b0;
    if (!in_set) begin
      // Edit buttons are ignored in RUN; the idle timer rests at zero.
      idle_next = '0;
      if (mode_ev) begin
        state_next = ST_SET_SEC;
      end
    end else if (mode_ev) begin
      idle_next  = '0;
      state_next = next_field(state_reg);
    end else if (inc_ev || dec_ev || rpt_fire) begin
      // Every accepted press restarts the timeout, even one suppressed
      // because both edit buttons are down.
      idle_next = '0;
      inc_next  = inc_fire || (rpt_fire && !rpt_is_dec);
      dec_next  = dec_fire || (rpt_fire && rpt_is_dec);
    end else if (idle_reg == IDLE_LAST) begin
      idle_next  = '0;
      state_next = ST_RUN;
    end else begin
      idle_next = idle_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      state_reg   <= ST_RUN;
      idle_reg    <= '0;
      set_reg     <= '0;
      editing_reg <= 1'b0;
      inc_reg     <= 1'b0;
      dec_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idle_reg    <= idle_next;
      set_reg     <= field_select(state_next);
      editing_reg <= (state_next != ST_RUN);
      inc_reg     <= inc_next;
      dec_reg     <= dec_next;
    end
  end

  assign set_sec   = set_reg[FIELD_SEC];
  assign set_min   = set_reg[FIELD_MIN];
  assign set_hour  = set_reg[FIELD_HOUR];
  assign set_day   = set_reg[FIELD_DAY];
  assign set_month = set_reg[FIELD_MONTH];
  assign set_year  = set_reg[FIELD_YEAR];
  assign inc       = inc_reg;
  assign dec       = dec_reg;
  assign editing   = editing_reg;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Testbench for set_mode_ctrl with shortened cycle constants.
// Output snapshot layout: {editing, dec, inc, set_year..set_sec}.
module tb_set_mode_ctrl;

  localparam int DB     = 4;
  localparam int DELAY  = 20;
  localparam int PERIOD = 5;
  localparam int IDLE   = 100;

  logic clk_50MHz = 1'b0;
  logic rst_n     = 1'b0;
  logic btn_mode_n = 1'b1;
  logic btn_inc_n  = 1'b1;
  logic btn_dec_n  = 1'b1;
  logic set_sec, set_min, set_hour, set_day, set_month, set_year;
  logic inc, dec, editing;

  always #5 clk_50MHz = ~clk_50MHz;

  set_mode_ctrl #(
    .DB_CYCLES        (DB),
    .RPT_DELAY_CYCLES (DELAY),
    .RPT_PERIOD_CYCLES(PERIOD),
    .IDLE_CYCLES      (IDLE)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .btn_mode_n(btn_mode_n),
    .btn_inc_n (btn_inc_n),
    .btn_dec_n (btn_dec_n),
    .set_sec   (set_sec),
    .set_min   (set_min),
    .set_hour  (set_hour),
    .set_day   (set_day),
    .set_month (set_month),
    .set_year  (set_year),
    .inc       (inc),
    .dec       (dec),
    .editing   (editing)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int inc_cnt  = 0;
  int dec_cnt  = 0;
  int both_cnt = 0;

  localparam logic [8:0] B_EDIT = 9'h100;
  localparam logic [8:0] B_DEC  = 9'h080;
  localparam logic [8:0] B_INC  = 9'h040;
  localparam logic [8:0] V_RUN  = 9'h000;

  typedef struct { string tag; logic [8:0] val; } exp_t;
  typedef struct { string tag; int val; } cexp_t;
  exp_t  sb[$];
  cexp_t cq[$];

`ifdef AUTO_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  function automatic logic [8:0] sel(input int f);
    logic [8:0] v;
    v = B_EDIT;
    v[f] = 1'b1;
    return v;
  endfunction

  function automatic logic [8:0] obs();
    return {editing, dec, inc, set_year, set_month, set_day, set_hour, set_min, set_sec};
  endfunction

  // Pulse counters sampled away from the active edge.
  always @(negedge clk_50MHz) begin
    if (inc) inc_cnt++;
    if (dec) dec_cnt++;
    if (inc && dec) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  // Press one button (0 mode, 1 inc, 2 dec) for 'hold' cycles, then let the release settle.
  task automatic press_btn(input int which, input int hold);
    case (which)
      0: btn_mode_n = 1'b0;
      1: btn_inc_n  = 1'b0;
      default: btn_dec_n = 1'b0;
    endcase
    tick(hold);
    btn_mode_n = 1'b1;
    btn_inc_n  = 1'b1;
    btn_dec_n  = 1'b1;
    tick(8);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    tick(3);
    sb.push_back('{"reset_outputs", V_RUN});
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    rst_n = 1'b1;
    tick(3);
    sb.push_back('{"after_reset_release", V_RUN});
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
  endtask

  task automatic test_mode_walk();
    exp_t e;
    btn_mode_n = 1'b0;
    sb.push_back('{"mode_cycle6_still_run", V_RUN});
    sb.push_back('{"mode_cycle7_set_sec", sel(0)});
    tick(6);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    tick(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    tick(3);
    btn_mode_n = 1'b1;
    tick(8);
    for (int k = 1; k <= 6; k++) begin
      sb.push_back('{$sformatf("mode_walk_%0d", k), (k < 6) ? sel(k) : V_RUN});
      press_btn(0, 10);
      e = sb.pop_front(); n_checks++;
      if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
      else $display("check %s observed %b", e.tag, obs());
    end
  endtask

  task automatic test_inc_in_run();
    exp_t  e;
    cexp_t c;
    int    base;
    base = inc_cnt;
    sb.push_back('{"run_inc_state", V_RUN});
    cq.push_back('{"run_inc_pulses", 0});
    press_btn(1, 12);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    c = cq.pop_front(); n_checks++;
    if ((inc_cnt - base) !== c.val) begin n_fail++; $display("FAIL %s: observed %0d expected %0d", c.tag, inc_cnt - base, c.val); end
    else $display("check %s observed %0d", c.tag, inc_cnt - base);
  endtask

  task automatic test_bounce();
    exp_t  e;
    cexp_t c;
    int    base;
    base = inc_cnt;
    cq.push_back('{"bounce_quiet", 0});
    cq.push_back('{"bounce_single", 1});
    for (int i = 0; i < 15; i++) begin
      btn_inc_n = ~btn_inc_n;
      tick(2);
    end
    c = cq.pop_front(); n_checks++;
    if ((inc_cnt - base) !== c.val) begin n_fail++; $display("FAIL %s: observed %0d expected %0d", c.tag, inc_cnt - base, c.val); end
    else $display("check %s observed %0d", c.tag, inc_cnt - base);
    // The last toggle left the line low two cycles ago; it now stays low.
    btn_inc_n = 1'b0;
    sb.push_back('{"bounce_before_pulse", sel(1)});
    sb.push_back('{"bounce_pulse", sel(1) | B_INC});
    sb.push_back('{"bounce_after_pulse", sel(1)});
    tick(4);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    tick(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    tick(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    btn_inc_n = 1'b1;
    tick(8);
    c = cq.pop_front(); n_checks++;
    if ((inc_cnt - base) !== c.val) begin n_fail++; $display("FAIL %s: observed %0d expected %0d", c.tag, inc_cnt - base, c.val); end
    else $display("check %s observed %0d", c.tag, inc_cnt - base);
  endtask

  task automatic test_both_then_dec();
    exp_t  e;
    cexp_t c;
    int    base_i, base_d;
    base_i = inc_cnt;
    base_d = dec_cnt;
    cq.push_back('{"both_no_pulses", 0});
    sb.push_back('{"both_state", sel(2)});
    btn_inc_n = 1'b0;
    btn_dec_n = 1'b0;
    tick(14);
    btn_inc_n = 1'b1;
    btn_dec_n = 1'b1;
    tick(8);
    c = cq.pop_front(); n_checks++;
    if ((inc_cnt - base_i) + (dec_cnt - base_d) !== c.val) begin
      n_fail++; $display("FAIL %s: observed %0d expected %0d", c.tag, (inc_cnt - base_i) + (dec_cnt - base_d), c.val);
    end else $display("check %s observed %0d", c.tag, (inc_cnt - base_i) + (dec_cnt - base_d));
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    base_d = dec_cnt;
    btn_dec_n = 1'b0;
    sb.push_back('{"dec_pulse", sel(2) | B_DEC});
    sb.push_back('{"dec_pulse_end", sel(2)});
    cq.push_back('{"dec_single", 1});
    tick(7);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    tick(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    tick(2);
    btn_dec_n = 1'b1;
    tick(8);
    c = cq.pop_front(); n_checks++;
    if ((dec_cnt - base_d) !== c.val) begin n_fail++; $display("FAIL %s: observed %0d expected %0d", c.tag, dec_cnt - base_d, c.val); end
    else $display("check %s observed %0d", c.tag, dec_cnt - base_d);
  endtask

  // Mode and inc land together: mode wins, inc is dropped (SET_HOUR -> SET_DAY).
  task automatic test_mode_wins();
    exp_t e;
    btn_mode_n = 1'b0;
    btn_inc_n  = 1'b0;
    sb.push_back('{"mode_wins_step", sel(3)});
    sb.push_back('{"mode_wins_no_inc", sel(3)});
    tick(7);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    tick(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    btn_mode_n = 1'b1;
    btn_inc_n  = 1'b1;
    tick(8);
  endtask

  // Hold inc in SET_DAY; check every cycle up to 52 after the first pulse.
  task automatic test_repeat();
    exp_t e;
    logic [8:0] v;
    btn_inc_n = 1'b0;
    sb.push_back('{"repeat_first", sel(3) | B_INC});
    for (int off = 1; off <= 52; off++) begin
      v = sel(3);
      if (RPT_ON && off >= DELAY && off <= 50 && ((off - DELAY) % PERIOD) == 0) v = v | B_INC;
      sb.push_back('{$sformatf("repeat_off_%0d", off), v});
    end
    tick(7);
    for (int off = 0; off <= 52; off++) begin
      if (off > 0) tick(1);
      e = sb.pop_front(); n_checks++;
      if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
      else $display("check %s observed %b", e.tag, obs());
    end
    btn_inc_n = 1'b1;
    tick(10);
  endtask

  task automatic test_idle_timeout();
    exp_t e;
    int   waited;
    press_btn(0, 10);
    sb.push_back('{"idle_set_year", sel(5)});
    sb.push_back('{"idle_still_set_year", sel(5)});
    sb.push_back('{"idle_back_to_run", V_RUN});
    press_btn(0, 10);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    // SET_YEAR appeared 11 cycles ago; timeout is about IDLE cycles after that.
    tick(IDLE - 20);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    waited = 0;
    while (editing && waited < 40) begin
      tick(1);
      waited++;
    end
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b after %0d cycles", e.tag, obs(), e.val, waited); end
    else $display("check %s observed %b after %0d cycles", e.tag, obs(), waited);
  endtask

  task automatic test_reset_mid_repeat();
    exp_t  e;
    cexp_t c;
    int    base;
    press_btn(0, 10);
    btn_inc_n = 1'b0;
    sb.push_back('{"rst_pre_pulse", sel(0) | B_INC});
    sb.push_back('{"rst_mid_repeat", V_RUN});
    sb.push_back('{"rst_held_mode_ignored", V_RUN});
    tick(7);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    tick(DELAY + 2);
    btn_mode_n = 1'b0;
    rst_n = 1'b0;
    tick(1);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    tick(2);
    rst_n = 1'b1;
    base = inc_cnt;
    cq.push_back('{"rst_no_pulses_after", 0});
    tick(20);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
    c = cq.pop_front(); n_checks++;
    if ((inc_cnt - base) !== c.val) begin n_fail++; $display("FAIL %s: observed %0d expected %0d", c.tag, inc_cnt - base, c.val); end
    else $display("check %s observed %0d", c.tag, inc_cnt - base);
    btn_mode_n = 1'b1;
    btn_inc_n  = 1'b1;
    tick(8);
    sb.push_back('{"rst_fresh_mode_press", sel(0)});
    press_btn(0, 10);
    e = sb.pop_front(); n_checks++;
    if (obs() !== e.val) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.val); end
    else $display("check %s observed %b", e.tag, obs());
  endtask

  task automatic test_exclusive();
    cexp_t c;
    cq.push_back('{"inc_dec_overlap_cycles", 0});
    c = cq.pop_front(); n_checks++;
    if (both_cnt !== c.val) begin n_fail++; $display("FAIL %s: observed %0d expected %0d", c.tag, both_cnt, c.val); end
    else $display("check %s observed %0d", c.tag, both_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode_walk();
    test_inc_in_run();
    press_btn(0, 10);
    press_btn(0, 10);       // SET_MIN
    test_bounce();
    press_btn(0, 10);       // SET_HOUR
    test_both_then_dec();
    test_mode_wins();       // ends in SET_DAY
    test_repeat();
    test_idle_timeout();    // SET_MONTH, SET_YEAR, timeout to RUN
    test_reset_mid_repeat();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
